// File: rtl/frame_update_sequencer.sv
// frame_update_sequencer
// ----------------------
// Per-frame scheduler for the pong game logic. It runs in the pixel clock
// domain and watches vsync from the video timing generator. On every
// FRAME_DIV-th frame event it walks four game-update stages (paddle 1,
// paddle 2, ball, score) through one-hot req/ack handshakes, so that all
// game state changes land inside vertical blanking.
//
// Optional feature: define STAGE_TIMEOUT_EN to give every stage a watchdog.
// If a stage waits TIMEOUT cycles without an ack, the stage is skipped and
// timeout_err is set. Without the macro the FSM waits indefinitely for each
// ack, and timeout_err is tied to 0.
//
// Parameters:
//   FRAME_DIV  launch one sequence every FRAME_DIV frame events (1..255)
//   VSYNC_POL  asserted level of vsync (1 = active-high)
//   TIMEOUT    max cycles a stage waits for its ack (STAGE_TIMEOUT_EN only)
//
// Ports:
//   clk          pixel clock; all logic runs on the rising edge
//   reset        asynchronous, active-low reset (0 = reset)
//   vsync        vsync from the timing generator, same clock domain
//   pause        1 = do not launch new sequences (sampled at frame events)
//   stage_ack    per-stage completion: bit0 p1, bit1 p2, bit2 ball, bit3 score
//   stage_req    one-hot stage request, registered
//   busy         1 while a sequence is in progress
//   frame_done   one-cycle pulse after the last stage completes
//   frame_cnt    count of launched sequences (wraps)
//   overrun      sticky: a launch was due while a sequence was still running
//   timeout_err  sticky: a stage timed out

module frame_update_sequencer #(
  parameter int unsigned FRAME_DIV = 1,
  parameter logic        VSYNC_POL = 1'b1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        pause,
  input  logic [3:0]  stage_ack,
  output logic [3:0]  stage_req,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  state_t     state;
  logic       vsync_prev;
  logic [7:0] divider;

  logic       frame_event;
  logic       launch_due;
  logic       in_stage;
  logic [1:0] stage_idx;
  logic       stage_hit;
  logic       stage_expired;
  logic       stage_advance;

  // A frame event is the first cycle vsync sits at its asserted level. The
  // history register resets to the deasserted level, so a vsync already
  // asserted when reset releases counts as a fresh edge.
  always_comb begin
    frame_event = (vsync == VSYNC_POL) && (vsync_prev != VSYNC_POL);
    launch_due  = frame_event && !pause && (divider == DIV_LAST);
  end

  // Only the ack bit of the active stage matters; the other bits are ignored.
  always_comb begin
    in_stage  = 1'b0;
    stage_idx = 2'd0;
    case (state)
      S0: begin in_stage = 1'b1; stage_idx = 2'd0; end
      S1: begin in_stage = 1'b1; stage_idx = 2'd1; end
      S2: begin in_stage = 1'b1; stage_idx = 2'd2; end
      S3: begin in_stage = 1'b1; stage_idx = 2'd3; end
      default: begin in_stage = 1'b0; stage_idx = 2'd0; end
    endcase
    stage_hit     = in_stage && stage_ack[stage_idx];
    stage_advance = stage_hit || stage_expired;
  end

`ifdef STAGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] stage_cycles;

  // stage_cycles holds the number of completed cycles spent in the current
  // stage, so reaching T_LAST means this is the TIMEOUT-th cycle. An ack on
  // that same cycle wins and no error is recorded.
  assign stage_expired = in_stage && !stage_hit && (stage_cycles == T_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_cycles <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (!in_stage || stage_advance) begin
        stage_cycles <= '0;
      end else begin
        stage_cycles <= stage_cycles + 1'b1;
      end
      if (stage_expired) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign stage_expired = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // Frame divider. It only moves on unpaused frame events, so pausing
  // freezes the phase of the game-speed divider rather than resetting it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_prev <= ~VSYNC_POL;
      divider    <= 8'd0;
    end else begin
      vsync_prev <= vsync;
      if (frame_event && !pause) begin
        if (divider == DIV_LAST) begin
          divider <= 8'd0;
        end else begin
          divider <= divider + 8'd1;
        end
      end
    end
  end

  // Sequencer. A launch that arrives while a sequence (including DONE) is
  // still running is dropped and only recorded in overrun; the running
  // sequence is left untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      stage_req  <= 4'b0000;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
      overrun    <= 1'b0;
    end else begin
      if (launch_due && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (launch_due) begin
            state     <= S0;
            stage_req <= 4'b0001;
            busy      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        S0: begin
          if (stage_advance) begin
            state     <= S1;
            stage_req <= 4'b0010;
          end
        end
        S1: begin
          if (stage_advance) begin
            state     <= S2;
            stage_req <= 4'b0100;
          end
        end
        S2: begin
          if (stage_advance) begin
            state     <= S3;
            stage_req <= 4'b1000;
          end
        end
        S3: begin
          if (stage_advance) begin
            state      <= DONE;
            stage_req  <= 4'b0000;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          stage_req  <= 4'b0000;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_update_sequencer.sv
// tb_frame_update_sequencer
// -------------------------
// Self-checking bench for frame_update_sequencer. Two instances share the
// same stimulus:
//   dut_a: FRAME_DIV=1, active-high vsync
//   dut_b: FRAME_DIV=3, active-low vsync (driven with the inverted vsync)
// A behavioural model tracks each instance as a stage number, an event
// count and a few sticky flags. Directed scenarios run first, followed by
// a randomized phase. The bench builds with or without STAGE_TIMEOUT_EN.

module tb_frame_update_sequencer;

  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        vsync_b;
  logic        pause;
  logic [3:0]  stage_ack;

  logic [3:0]  req_a, req_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic [15:0] cnt_a, cnt_b;
  logic        over_a, over_b;
  logic        terr_a, terr_b;

  int checks = 0;
  int errors = 0;

  // Model state; index 0 = dut_a, 1 = dut_b. Stage -1 = idle, 4 = done.
  int          div_cfg [2] = '{1, 3};
  logic        pol_cfg [2] = '{1'b1, 1'b0};
  logic        m_prev  [2];
  int          m_events[2];
  int          m_stage [2];
  int          m_wait  [2];
  logic [15:0] m_cnt   [2];
  logic        m_over  [2];
  logic        m_terr  [2];

  always #5 clk = ~clk;

  assign vsync_b = ~vsync;

  frame_update_sequencer #(
    .FRAME_DIV(1), .VSYNC_POL(1'b1), .TIMEOUT(TIMEOUT_CYC)
  ) dut_a (
    .clk(clk), .reset(reset), .vsync(vsync), .pause(pause),
    .stage_ack(stage_ack), .stage_req(req_a), .busy(busy_a),
    .frame_done(done_a), .frame_cnt(cnt_a), .overrun(over_a),
    .timeout_err(terr_a)
  );

  frame_update_sequencer #(
    .FRAME_DIV(3), .VSYNC_POL(1'b0), .TIMEOUT(TIMEOUT_CYC)
  ) dut_b (
    .clk(clk), .reset(reset), .vsync(vsync_b), .pause(pause),
    .stage_ack(stage_ack), .stage_req(req_b), .busy(busy_b),
    .frame_done(done_b), .frame_cnt(cnt_b), .overrun(over_b),
    .timeout_err(terr_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prev[d]   = ~pol_cfg[d];
      m_events[d] = 0;
      m_stage[d]  = -1;
      m_wait[d]   = 0;
      m_cnt[d]    = 16'd0;
      m_over[d]   = 1'b0;
      m_terr[d]   = 1'b0;
    end
  endtask

  // Advance the model by one rising edge with the inputs seen at that edge.
  task automatic model_step(input logic vs, input logic ps, input logic [3:0] ack);
    for (int d = 0; d < 2; d++) begin
      logic v;
      logic ev;
      logic due;
      logic accepted;
      v   = (d == 1) ? ~vs : vs;
      ev  = (v == pol_cfg[d]) && (m_prev[d] != pol_cfg[d]);
      m_prev[d] = v;
      due = 1'b0;
      if (ev && !ps) begin
        m_events[d]++;
        due = ((m_events[d] % div_cfg[d]) == 0);
      end
      if (m_stage[d] == -1) begin
        if (due) begin
          m_stage[d] = 0;
          m_wait[d]  = 0;
          m_cnt[d]   = m_cnt[d] + 16'd1;
        end
      end else begin
        if (due) m_over[d] = 1'b1;
        if (m_stage[d] == 4) begin
          m_stage[d] = -1;
        end else begin
          accepted = ack[m_stage[d]];
`ifdef STAGE_TIMEOUT_EN
          m_wait[d]++;
          if (!accepted && (m_wait[d] == TIMEOUT_CYC)) begin
            accepted  = 1'b1;
            m_terr[d] = 1'b1;
          end
`endif
          if (accepted) begin
            m_stage[d]++;
            m_wait[d] = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_req(input int d);
    if (m_stage[d] >= 0 && m_stage[d] <= 3) return 32'd1 << m_stage[d];
    return 32'd0;
  endfunction

  task automatic compare_all();
    checkOutput("a.stage_req",   {28'd0, req_a},  exp_req(0));
    checkOutput("a.busy",        {31'd0, busy_a}, {31'd0, m_stage[0] != -1});
    checkOutput("a.frame_done",  {31'd0, done_a}, {31'd0, m_stage[0] == 4});
    checkOutput("a.frame_cnt",   {16'd0, cnt_a},  {16'd0, m_cnt[0]});
    checkOutput("a.overrun",     {31'd0, over_a}, {31'd0, m_over[0]});
    checkOutput("a.timeout_err", {31'd0, terr_a}, {31'd0, m_terr[0]});
    checkOutput("b.stage_req",   {28'd0, req_b},  exp_req(1));
    checkOutput("b.busy",        {31'd0, busy_b}, {31'd0, m_stage[1] != -1});
    checkOutput("b.frame_done",  {31'd0, done_b}, {31'd0, m_stage[1] == 4});
    checkOutput("b.frame_cnt",   {16'd0, cnt_b},  {16'd0, m_cnt[1]});
    checkOutput("b.overrun",     {31'd0, over_b}, {31'd0, m_over[1]});
    checkOutput("b.timeout_err", {31'd0, terr_b}, {31'd0, m_terr[1]});
  endtask

  // Called at a falling edge: drive inputs, run one rising edge, then
  // compare both instances at the following falling edge.
  task automatic applyStimulus(input logic vs, input logic ps, input logic [3:0] ack);
    vsync     = vs;
    pause     = ps;
    stage_ack = ack;
    model_step(vs, ps, ack);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // One vsync pulse followed by idle cycles.
  task automatic vsync_pulse(input logic ps, input logic [3:0] ack);
    applyStimulus(1'b1, ps, ack);
    repeat (7) applyStimulus(1'b0, ps, ack);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    reset     = 1'b0;
    vsync     = 1'b0;
    pause     = 1'b0;
    stage_ack = 4'b0000;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic saw_done;

    reset     = 1'b0;
    vsync     = 1'b0;
    pause     = 1'b0;
    stage_ack = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;

    // Basic sequence with acks held high.
    $display("[TB] basic sequence");
    applyStimulus(1'b0, 1'b0, 4'hF);
    applyStimulus(1'b1, 1'b0, 4'hF);
    checkOutput("t1.req0", {28'd0, req_a}, 32'h1);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 4'hF);
      checkOutput("t1.req", {28'd0, req_a}, 32'd1 << i);
    end
    applyStimulus(1'b1, 1'b0, 4'hF);
    checkOutput("t1.done", {31'd0, done_a}, 32'h1);
    checkOutput("t1.busy_in_done", {31'd0, busy_a}, 32'h1);
    applyStimulus(1'b0, 1'b0, 4'hF);
    checkOutput("t1.busy_low", {31'd0, busy_a}, 32'h0);
    checkOutput("t1.cnt", {16'd0, cnt_a}, 32'h1);

    // Frame divider and pause.
    $display("[TB] divider and pause");
    do_reset();
    for (int p = 0; p < 6; p++) vsync_pulse(1'b0, 4'hF);
    checkOutput("t2.cnt_a", {16'd0, cnt_a}, 32'd6);
    checkOutput("t2.cnt_b", {16'd0, cnt_b}, 32'd2);
    for (int p = 0; p < 3; p++) vsync_pulse(1'b1, 4'hF);
    checkOutput("t2.paused_cnt_a", {16'd0, cnt_a}, 32'd6);
    checkOutput("t2.paused_cnt_b", {16'd0, cnt_b}, 32'd2);
    for (int p = 0; p < 2; p++) vsync_pulse(1'b0, 4'hF);
    checkOutput("t2.frozen_cnt_b", {16'd0, cnt_b}, 32'd2);
    vsync_pulse(1'b0, 4'hF);
    checkOutput("t2.resume_cnt_b", {16'd0, cnt_b}, 32'd3);

    // Overrun while a stage is stalled.
    $display("[TB] overrun");
    do_reset();
    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("t3.overrun", {31'd0, over_a}, 32'h1);
    checkOutput("t3.cnt", {16'd0, cnt_a}, 32'h1);
    checkOutput("t3.req_held", {28'd0, req_a}, 32'h2);
    applyStimulus(1'b0, 1'b0, 4'b0010);
    applyStimulus(1'b0, 1'b0, 4'b0100);
    applyStimulus(1'b0, 1'b0, 4'b1000);
    checkOutput("t3.done", {31'd0, done_a}, 32'h1);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    checkOutput("t3.idle", {31'd0, busy_a}, 32'h0);

`ifdef STAGE_TIMEOUT_EN
    // Stage 1 never acked: it must time out after TIMEOUT cycles.
    $display("[TB] stage timeout");
    do_reset();
    applyStimulus(1'b1, 1'b0, 4'b1101);
    n = 0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 1'b0, 4'b1101);
      if (req_a == 4'b0010) n++;
      if (done_a) saw_done = 1'b1;
    end
    checkOutput("t4.s1_cycles", n, TIMEOUT_CYC);
    checkOutput("t4.timeout_err", {31'd0, terr_a}, 32'h1);
    checkOutput("t4.done_seen", {31'd0, saw_done}, 32'h1);
`endif

    // Reset in the middle of a sequence.
    $display("[TB] reset mid-sequence");
    do_reset();
    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 1'b0, 4'b0010);
    checkOutput("t5.req_before", {28'd0, req_a}, 32'h4);
    reset = 1'b0;
    #1;
    checkOutput("t5.req_now", {28'd0, req_a}, 32'h0);
    checkOutput("t5.busy_now", {31'd0, busy_a}, 32'h0);
    checkOutput("t5.cnt_now", {16'd0, cnt_a}, 32'h0);
    do_reset();
    n = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 4'hF);
      if (req_a != 4'b0000) n++;
    end
    checkOutput("t5.no_req", n, 0);
    applyStimulus(1'b1, 1'b0, 4'hF);
    checkOutput("t5.fresh_req", {28'd0, req_a}, 32'h1);

    // Randomized phase.
    $display("[TB] random phase");
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic       vs;
      logic       ps;
      logic [3:0] ack;
      vs  = ($urandom_range(0, 5) == 0);
      ps  = ($urandom_range(0, 9) == 0);
      ack = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) begin
        do_reset();
      end else begin
        applyStimulus(vs, ps, ack);
      end
    end

    // frame_cnt wrap from 0xFFFF.
    $display("[TB] frame_cnt wrap");
    do_reset();
    applyStimulus(1'b0, 1'b0, 4'hF);
    force dut_a.frame_cnt = 16'hFFFF;
    #1;
    release dut_a.frame_cnt;
    m_cnt[0] = 16'hFFFF;
    applyStimulus(1'b1, 1'b0, 4'hF);
    checkOutput("t6.wrap", {16'd0, cnt_a}, 32'h0);
    checkOutput("t6.busy", {31'd0, busy_a}, 32'h1);
    repeat (6) applyStimulus(1'b0, 1'b0, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_update_sequencer.md
Name: frame_update_sequencer

Overview:
Per-frame scheduler for the pong game logic behind the HDMI video pipeline. Runs in the pixel clock domain and watches the video timing generator's vsync. On each scheduled frame it sequences four game-update stages (paddle 1, paddle 2, ball, score) through req/ack handshakes, so that all state changes land in vertical blanking. Reports frame count, busy, overrun and stage-timeout status.

Parameters:
FRAME_DIV, 1, launch one update sequence every FRAME_DIV frame events (1..255); sets game speed
VSYNC_POL, 1, asserted level of vsync (1 = active-high)
TIMEOUT, 1024, max cycles a stage req waits for ack (used only with STAGE_TIMEOUT_EN)

Ports:
clk  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
vsync  in  1  vsync from timing generator, same clock domain
pause  in  1  1 = do not launch new sequences
stage_ack  in  4  per-stage completion; bit0 p1, bit1 p2, bit2 ball, bit3 score
stage_req  out  4  one-hot stage request, registered
busy  out  1  1 while a sequence is in progress
frame_done  out  1  one-cycle pulse after the last stage completes
frame_cnt  out  16  count of launched sequences
overrun  out  1  sticky: a launch was due while busy
timeout_err  out  1  sticky: a stage timed out (0 when STAGE_TIMEOUT_EN is undefined)

Behaviour:
- Reset (reset=0, async): stage_req=0, busy=0, frame_done=0, frame_cnt=0, overrun=0, timeout_err=0, divider=0, FSM=IDLE, vsync history register = deasserted level.
- Frame event: one cycle where vsync == VSYNC_POL and the previous sampled vsync != VSYNC_POL. One-register edge detect; no synchronizer.
- Divider: 8-bit, advances on each frame event while pause=0 and holds while pause=1. When the divider is FRAME_DIV-1 at a frame event, the divider returns to 0 and a launch is due.
- Launch due while FSM==IDLE: go to S0 on the next edge. stage_req=0001 and busy=1 from that edge. frame_cnt increments on the same edge, wrapping 0xFFFF->0x0000.
- Launch due while FSM!=IDLE: set overrun, drop the launch, leave frame_cnt unchanged, and keep the running sequence undisturbed.
- FSM: IDLE -> S0 -> S1 -> S2 -> S3 -> DONE -> IDLE.
- In Sn, stage_req = one-hot bit n, held until stage_ack[n] is sampled 1. On that edge the FSM moves to Sn+1, so stage_req moves to the next bit with no gap cycle. Ack bits other than n are ignored.
- S3 ack -> DONE: stage_req=0, frame_done=1 for exactly one cycle, busy stays 1. DONE -> IDLE: busy=0, frame_done=0.
- Latency with immediate ack: frame event -> stage_req bit0 is 1 edge. An ack held high for all stages completes in 4 cycles; frame_done follows 1 cycle after the S3 ack.
- pause is sampled only at frame events. An in-progress sequence always runs to DONE.
- A stage_ack already high when its Sn is entered is accepted on the first cycle of Sn.
- overrun and timeout_err clear only on reset.
- Reset mid-sequence aborts the sequence immediately. No request is re-issued after reset release; the next frame event starts fresh.

Optional Feature:
- Macro: STAGE_TIMEOUT_EN.
- Defined:
  - A cycle counter (clog2(TIMEOUT)+1 bits) clears on each Sn entry and counts while in Sn.
  - If TIMEOUT cycles pass with no ack, set timeout_err and advance to the next stage exactly as if acked. S3 advances to DONE, and frame_done still pulses.
  - An ack arriving on the same cycle the counter expires counts as an ack; timeout_err is not set.
- Undefined: no counter; the FSM waits indefinitely in Sn; timeout_err is tied to 0.

Test Plan:
- Reset then vsync rising, FRAME_DIV=1, stage_ack=4'b1111 held -> stage_req 0001,0010,0100,1000 on consecutive cycles, frame_done 1 cycle later, frame_cnt=1, busy low after DONE.
- FRAME_DIV=3, 6 vsync pulses, immediate acks -> exactly 2 sequences, frame_cnt=2; pause=1 over the next 3 pulses -> no launches, divider frozen.
- stage_ack held 0 and second vsync arrives while in S1 -> overrun=1, frame_cnt stays 1, stage_req stays 0010; ack S1..S3 -> sequence completes normally.
- STAGE_TIMEOUT_EN, TIMEOUT=16, ack only stages 0,2,3 -> S1 request held 16 cycles then advances, timeout_err=1, frame_done still pulses.
- Assert reset low for 1 cycle while stage_req=0100 -> all outputs 0 immediately; after release no request until the next vsync edge.
- Preload frame_cnt to 0xFFFF via 65535 fast sequences (or force) and run one more -> frame_cnt=0x0000.
